// File: rtl/text_pkg.sv
// Shared types and constants for the text console: FSM states, control codes, pixel latency and the base font.
package text_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR      = 2'd0,
        ST_IDLE       = 2'd1,
        ST_SCROLL_CLR = 2'd2
    } state_e;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_TILDE = 8'h7E;

    localparam int PIX_LATENCY = 4;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CHAR_SPACE) && (c <= CHAR_TILDE);
    endfunction

    // 8x16 base font: 'A' is drawn in full, other printables show a hollow box, space and controls are blank.
    function automatic logic [7:0] font8x16(input logic [6:0] idx, input logic [3:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        if (idx == 7'h41) begin
            case (row)
                4'd2:    bits = 8'h10;
                4'd3:    bits = 8'h38;
                4'd4:    bits = 8'h6C;
                4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: bits = 8'hC6;
                4'd7:    bits = 8'hFE;
                default: bits = 8'h00;
            endcase
        end else if ((idx > 7'h20) && (idx < 7'h7F)) begin
            if ((row == 4'd2) || (row == 4'd12)) begin
                bits = 8'h7E;
            end else if ((row > 4'd2) && (row < 4'd12)) begin
                bits = 8'h42;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Glyph ROM: 128 glyphs of GLYPH_H rows x GLYPH_W bits (MSB = leftmost pixel), one-cycle registered read.
// The 8x16 base font is resampled by shifts when the glyph size differs; no backpressure.
module glyph_rom
    import text_pkg::*;
#(
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [6:0]                 idx_i,
    input  logic [$clog2(GLYPH_H)-1:0] row_i,
    output logic [GLYPH_W-1:0]         bits_o
);

    localparam int RH = $clog2(GLYPH_H);
    localparam int RW = $clog2(GLYPH_W);

    logic [3:0]         base_row;
    logic [7:0]         base_bits;
    logic [GLYPH_W-1:0] bits_d;
    logic [GLYPH_W-1:0] bits_q;

    always_comb begin
        base_row  = 4'((32'(row_i) * 16) >> RH);
        base_bits = font8x16(idx_i, base_row);
        bits_d    = '0;
        for (int b = 0; b < GLYPH_W; b++) begin
            bits_d[b] = base_bits[3'((b * 8) >> RW)];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/text_console.sv
// Character-grid console: byte stream in (ready low while clearing/scrolling), 4-cycle pixel render pipeline out.
// Optional blinking inverted cursor when TEXT_CURSOR_EN is defined.
module text_console
    import text_pkg::*;
#(
    parameter int COLS         = 32,
    parameter int ROWS         = 8,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int SCALE_LOG2   = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_in,
    input  logic [10:0]               hcount_in,
    input  logic [9:0]                vcount_in,
    input  logic                      nf_in,
    input  logic [10:0]               x_in,
    input  logic [9:0]                y_in,
    input  logic [23:0]               fg_color_in,
    input  logic [23:0]               bg_color_in,
    input  logic                      bg_en_in,
    input  logic                      char_valid_in,
    input  logic [7:0]                char_in,
    output logic                      char_ready_out,
    output logic [$clog2(COLS)-1:0]   cursor_col_out,
    output logic [$clog2(ROWS)-1:0]   cursor_row_out,
    output logic [7:0]                red_out,
    output logic [7:0]                green_out,
    output logic [7:0]                blue_out,
    output logic                      hit_out
);

    localparam int CW    = $clog2(COLS);
    localparam int RWD   = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int GWL   = $clog2(GLYPH_W);
    localparam int GHL   = $clog2(GLYPH_H);
    localparam int BOX_W = (COLS * GLYPH_W) << SCALE_LOG2;
    localparam int BOX_H = (ROWS * GLYPH_H) << SCALE_LOG2;

    logic [7:0] buf_mem [CELLS];

    state_e         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RWD-1:0] row_q, row_d;
    logic [RWD-1:0] top_q, top_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [7:0]     wdata;
    logic           adv_row;

    function automatic logic [RWD-1:0] wrap_row(input logic [RWD-1:0] a, input logic [RWD-1:0] b);
        logic [RWD:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (RWD+1)'(ROWS)) begin
            sum = sum - (RWD+1)'(ROWS);
        end
        return sum[RWD-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RWD-1:0] prow, input logic [CW-1:0] col);
        return AW'(int'(prow) * COLS + int'(col));
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = cell_addr(wrap_row(row_q, top_q), col_q);
        wdata   = CHAR_SPACE;
        adv_row = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                if (cnt_q == AW'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_SCROLL_CLR: begin
                // top_q already points past the old first row, which is now the bottom row.
                we    = 1'b1;
                waddr = cell_addr(wrap_row(RWD'(ROWS - 1), top_q), CW'(cnt_q));
                if (cnt_q == AW'(COLS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (char_valid_in) begin
                    if (is_printable(char_in)) begin
                        we    = 1'b1;
                        wdata = char_in;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d   = '0;
                            adv_row = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (char_in == CHAR_LF) begin
                        col_d   = '0;
                        adv_row = 1'b1;
                    end else if (char_in == CHAR_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - CW'(1);
                            we    = 1'b1;
                            waddr = cell_addr(wrap_row(row_q, top_q), col_q - CW'(1));
                        end
                    end else if (char_in == CHAR_FF) begin
                        state_d = ST_CLEAR;
                        top_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        if (adv_row) begin
            if (row_q == RWD'(ROWS - 1)) begin
                top_d   = wrap_row(RWD'(1), top_q);
                state_d = ST_SCROLL_CLR;
                cnt_d   = '0;
            end else begin
                row_d = row_q + RWD'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_CLEAR;
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (we) begin
            buf_mem[waddr] <= wdata;
        end
    end

    assign char_ready_out = (state_q == ST_IDLE);
    assign cursor_col_out = col_q;
    assign cursor_row_out = row_q;

    logic [11:0]    rel_x, rel_y;
    logic           in_box;
    logic [CW-1:0]  cell_c;
    logic [RWD-1:0] cell_r;
    logic           cur_cell;

    assign rel_x  = {1'b0, hcount_in} - {1'b0, x_in};
    assign rel_y  = {2'b00, vcount_in} - {2'b00, y_in};
    assign in_box = (hcount_in >= x_in) && (vcount_in >= y_in) &&
                    (rel_x < 12'(BOX_W)) && (rel_y < 12'(BOX_H));
    assign cell_c = CW'(rel_x >> (SCALE_LOG2 + GWL));
    assign cell_r = RWD'(rel_y >> (SCALE_LOG2 + GHL));

`ifdef TEXT_CURSOR_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] frame_q;
    logic          blink_q;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_q <= '0;
            blink_q <= 1'b1;
        end else if (nf_in) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_q <= '0;
                blink_q <= ~blink_q;
            end else begin
                frame_q <= frame_q + FW'(1);
            end
        end
    end

    assign cur_cell = blink_q && (cell_c == col_q) && (cell_r == row_q);
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_nf;
    assign unused_nf = nf_in;
    assign cur_cell  = 1'b0;
`endif

    logic           s1_vld_q, s2_vld_q, s3_vld_q;
    logic           s1_inv_q, s2_inv_q, s3_inv_q;
    logic [AW-1:0]  s1_addr_q;
    logic [GWL-1:0] s1_gx_q, s2_gx_q, s3_gx_q;
    logic [GHL-1:0] s1_gy_q, s2_gy_q;
    logic [6:0]     s2_ch_q;
    logic [GLYPH_W-1:0] rom_bits;
    logic           pix_bit;
    logic [23:0]    rgb_d, rgb_q;
    logic           hit_d, hit_q;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld_q  <= 1'b0;
            s1_inv_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_gx_q   <= '0;
            s1_gy_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_inv_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_gx_q   <= '0;
            s2_gy_q   <= '0;
            s3_vld_q  <= 1'b0;
            s3_inv_q  <= 1'b0;
            s3_gx_q   <= '0;
            rgb_q     <= '0;
            hit_q     <= 1'b0;
        end else begin
            s1_vld_q  <= in_box;
            s1_inv_q  <= cur_cell;
            s1_addr_q <= cell_addr(wrap_row(cell_r, top_q), cell_c);
            s1_gx_q   <= GWL'(rel_x >> SCALE_LOG2);
            s1_gy_q   <= GHL'(rel_y >> SCALE_LOG2);
            s2_vld_q  <= s1_vld_q;
            s2_inv_q  <= s1_inv_q;
            s2_ch_q   <= buf_mem[s1_addr_q][6:0];
            s2_gx_q   <= s1_gx_q;
            s2_gy_q   <= s1_gy_q;
            s3_vld_q  <= s2_vld_q;
            s3_inv_q  <= s2_inv_q;
            s3_gx_q   <= s2_gx_q;
            rgb_q     <= rgb_d;
            hit_q     <= hit_d;
        end
    end

    glyph_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H)
    ) u_rom (
        .clk_i  (pixel_clk_in),
        .rst_i  (rst_in),
        .idx_i  (s2_ch_q),
        .row_i  (s2_gy_q),
        .bits_o (rom_bits)
    );

    assign pix_bit = rom_bits[GWL'(GLYPH_W - 1) - s3_gx_q];

    always_comb begin
        rgb_d = '0;
        hit_d = 1'b0;
        if (s3_vld_q) begin
            if (s3_inv_q) begin
                hit_d = 1'b1;
                rgb_d = pix_bit ? bg_color_in : fg_color_in;
            end else if (pix_bit) begin
                hit_d = 1'b1;
                rgb_d = fg_color_in;
            end else if (bg_en_in) begin
                hit_d = 1'b1;
                rgb_d = bg_color_in;
            end
        end
    end

    assign red_out   = rgb_q[23:16];
    assign green_out = rgb_q[15:8];
    assign blue_out  = rgb_q[7:0];
    assign hit_out   = hit_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: reset/clear timing, glyph rendering at 2x scale, wrap, scroll and control codes.
module tb_text_console;

    localparam logic [23:0] FG = 24'hFF8040;
    localparam logic [23:0] BG = 24'h102030;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h;
    logic [9:0]  v;
    logic        nf;
    logic [10:0] xo;
    logic [9:0]  yo;
    logic        bg_en;
    logic        valid;
    logic [7:0]  ch;
    logic        ready;
    logic [4:0]  ccol;
    logic [2:0]  crow;
    logic [7:0]  r, g, b;
    logic        hit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    text_console #(
        .BLINK_FRAMES (2)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .hcount_in      (h),
        .vcount_in      (v),
        .nf_in          (nf),
        .x_in           (xo),
        .y_in           (yo),
        .fg_color_in    (FG),
        .bg_color_in    (BG),
        .bg_en_in       (bg_en),
        .char_valid_in  (valid),
        .char_in        (ch),
        .char_ready_out (ready),
        .cursor_col_out (ccol),
        .cursor_row_out (crow),
        .red_out        (r),
        .green_out      (g),
        .blue_out       (b),
        .hit_out        (hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] byte_v);
        int n;
        n = 0;
        @(negedge clk);
        valid = 1'b1;
        ch    = byte_v;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("send_accept_bound", 32'(n < 2000), 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Drives one pixel for a single cycle, then moves off-box, and samples exactly four edges later.
    task automatic probe(input int px, input int py, output logic p_hit, output logic [23:0] p_rgb);
        @(negedge clk);
        h = 11'(px);
        v = 10'(py);
        @(posedge clk);
        #1;
        h = '0;
        v = '0;
        repeat (3) @(posedge clk);
        #1;
        p_hit = hit;
        p_rgb = {r, g, b};
    endtask

    function automatic int count_nonspace();
        int c;
        c = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.buf_mem[i] !== 8'h20) c++;
        end
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        ph;
        logic [23:0] prgb;

        rst = 1'b1; h = '0; v = '0; nf = 1'b0; xo = 11'd100; yo = 10'd50;
        bg_en = 1'b0; valid = 1'b0; ch = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_col", ccol, 0);
        check("rst_row", crow, 0);
        check("rst_hit", hit, 0);
        check("rst_rgb", {r, g, b}, 0);

        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        check("init_clear_cycles", n, 256);
        check("init_cells_blank", count_nonspace(), 0);

        // Single glyph and render checks at (100,50), 2x scale
        send(8'h41);
        check("A_cell", dut.buf_mem[0], 8'h41);
        check("A_col", ccol, 1);
        check("A_row", crow, 0);
        probe(104, 56, ph, prgb);
        check("A_r3_on_hit", ph, 1);
        check("A_r3_on_rgb", prgb, FG);
        probe(103, 56, ph, prgb);
        check("A_r3_off_hit", ph, 0);
        check("A_r3_off_rgb", prgb, 0);
        probe(100, 64, ph, prgb);
        check("A_r7_left_hit", ph, 1);
        probe(114, 65, ph, prgb);
        check("A_r7_right_hit", ph, 0);
        probe(106, 51, ph, prgb);
        check("A_r0_hit", ph, 0);
        bg_en = 1'b1;
        probe(103, 56, ph, prgb);
        check("bg_cell_hit", ph, 1);
        check("bg_cell_rgb", prgb, BG);
        probe(99, 50, ph, prgb);
        check("left_of_box_hit", ph, 0);
        check("left_of_box_rgb", prgb, 0);
        probe(611, 50, ph, prgb);
        check("right_edge_in_hit", ph, 1);
        probe(612, 50, ph, prgb);
        check("right_edge_out_hit", ph, 0);
        probe(100, 305, ph, prgb);
        check("bottom_edge_in_hit", ph, 1);
        probe(100, 306, ph, prgb);
        check("bottom_edge_out_hit", ph, 0);
        bg_en = 1'b0;

        // Column wrap
        send(8'h0C);
        wait_ready(n);
        check("ff_clear_cycles", n, 256);
        for (int i = 0; i < 32; i++) send(8'(8'h41 + (i % 26)));
        send(8'h23);
        check("wrap_col", ccol, 1);
        check("wrap_row", crow, 1);
        check("wrap_cell32", dut.buf_mem[32], 8'h23);
        check("wrap_cell31", dut.buf_mem[31], 8'h46);

        // Scroll: text in rows 0 and 1, then 8 line feeds in total
        send(8'h0C);
        wait_ready(n);
        send(8'h5A);
        send(8'h0A);
        send(8'h41);
        for (int i = 0; i < 6; i++) send(8'h0A);
        check("pre_scroll_row", crow, 7);
        send(8'h0A);
        wait_ready(n);
        check("scroll_busy_cycles", n, 32);
        check("scroll_row", crow, 7);
        check("scroll_col", ccol, 0);
        check("scroll_bottom_cleared", dut.buf_mem[0], 8'h20);
        check("scroll_row1_kept", dut.buf_mem[32], 8'h41);
        probe(104, 56, ph, prgb);
        check("scroll_render_hit", ph, 1);
        check("scroll_render_rgb", prgb, FG);
        send(8'h51);
        check("scroll_write_phys0", dut.buf_mem[0], 8'h51);

        // Control codes
        send(8'h0C);
        wait_ready(n);
        check("cc_clear_cursor", {crow, ccol}, 0);
        send(8'h08);
        check("bs_col0_col", ccol, 0);
        check("bs_col0_row", crow, 0);
        send(8'h41);
        send(8'h42);
        send(8'h08);
        check("bs_col", ccol, 1);
        check("bs_cell1", dut.buf_mem[1], 8'h20);
        check("bs_cell0", dut.buf_mem[0], 8'h41);
        send(8'h07);
        check("ignored_byte_col", ccol, 1);
        send(8'h0C);
        wait_ready(n);
        check("ff2_clear_cycles", n, 256);
        check("ff2_cursor", {crow, ccol}, 0);
        check("ff2_blank", count_nonspace(), 0);

        // Reset asserted mid-stream with a live pixel in the pipeline
        send(8'h58);
        send(8'h59);
        bg_en = 1'b1;
        @(negedge clk);
        h = 11'd104;
        v = 10'd56;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_hit", hit, 1);
        @(negedge clk);
        valid = 1'b1;
        ch    = 8'h4B;
        rst   = 1'b1;
        #1;
        check("midrst_hit", hit, 0);
        check("midrst_rgb", {r, g, b}, 0);
        check("midrst_ready", ready, 0);
        check("midrst_cursor", {crow, ccol}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; h = '0; v = '0; bg_en = 1'b0;
        wait_ready(n);
        check("midrst_clear_cycles", n, 256);
        check("midrst_cursor_after", {crow, ccol}, 0);
        check("midrst_blank", count_nonspace(), 0);

`ifdef TEXT_CURSOR_EN
        probe(100, 50, ph, prgb);
        check("blink_f0_hit", ph, 1);
        check("blink_f0_rgb", prgb, FG);
        repeat (2) begin
            @(negedge clk); nf = 1'b1;
            @(negedge clk); nf = 1'b0;
        end
        probe(100, 50, ph, prgb);
        check("blink_f2_hit", ph, 0);
        repeat (2) begin
            @(negedge clk); nf = 1'b1;
            @(negedge clk); nf = 1'b0;
        end
        probe(100, 50, ph, prgb);
        check("blink_f4_hit", ph, 1);
        check("blink_f4_rgb", prgb, FG);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
